// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute sequencer for the SISC datapath
//   clk, rst     : clock, synchronous active-high reset
//   im_req/addr  : instruction fetch request and address (= pc)
//   im_ack/data  : memory accept, fetched word valid the same cycle
//   stat         : condition codes from statreg, used to resolve branches
//   ir, pc       : instruction register and program counter
//   rf_we, stat_en, alu_op, wb_sel, rd_sel : datapath control strobes
//   halted       : high while stopped on HALT
//   illegal      : one-cycle pulse while decoding an unknown opcode
module instr_sequencer #(
   parameter int PC_W = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            im_req,
   output logic [PC_W-1:0] im_addr,
   input  logic            im_ack,
   input  logic [31:0]     im_data,
   input  logic [3:0]      stat,
   output logic [31:0]     ir,
   output logic [PC_W-1:0] pc,
   output logic            rf_we,
   output logic            stat_en,
   output logic [1:0]      alu_op,
   output logic            wb_sel,
   output logic            rd_sel,
   output logic            halted,
   output logic            illegal
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   state_t state;
   logic [3:0] op, fop;
   logic known, is_alu, is_br, hit, taken;
   logic [PC_W-1:0] target;
   assign im_addr = pc;
   assign op      = ir[31:28];
   assign fop     = im_data[31:28];
   assign known   = fop inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hF};
   assign is_alu  = op == 4'h1 || op == 4'h2;
   assign is_br   = op inside {4'h4, 4'h5, 4'h6};
   assign hit     = |(stat & ir[27:24]);
   assign taken   = op == 4'h6 ? !hit : hit;
   // pc has already advanced past the branch, so BRR is relative to the next instruction
   assign target  = op == 4'h5 ? pc + ir[PC_W-1:0] : ir[PC_W-1:0];
   // Outputs are registered: each transition loads the strobes of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         im_req  <= 1'b0;
         rf_we   <= 1'b0;
         stat_en <= 1'b0;
         alu_op  <= 2'b00;
         wb_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               // right after reset im_req is still low; raise it first, ack is ignored until then
               if (!im_req) im_req <= 1'b1;
               else if (im_ack) begin
                  ir      <= im_data;
                  pc      <= pc + PC_W'(1);
                  im_req  <= 1'b0;
                  illegal <= !known;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               illegal <= 1'b0;
               if (op == 4'hF) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (is_alu) begin
                  stat_en <= 1'b1;
                  alu_op  <= op == 4'h1 ? 2'b01 : 2'b10;
                  state   <= S_EXEC;
               end else if (is_br) state <= S_EXEC;
               else begin
                  im_req <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_EXEC: begin
               stat_en <= 1'b0;
               if (is_alu) begin
                  rf_we  <= 1'b1;
                  wb_sel <= 1'b1;
                  rd_sel <= op == 4'h1;
                  state  <= S_WB;
               end else begin
                  if (taken) pc <= target;
                  im_req <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_WB: begin
               rf_we  <= 1'b0;
               wb_sel <= 1'b0;
               rd_sel <= 1'b0;
               alu_op <= 2'b00;
               im_req <= 1'b1;
               state  <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of the instr_sequencer fetch/decode/execute flow
module tb_instr_sequencer;
   logic clk = 1'b0, rst = 1'b1, im_ack, im_req, rf_we, stat_en, wb_sel, rd_sel, halted, illegal;
   logic auto_ack = 1'b0, man_ack = 1'b0;
   logic [15:0] im_addr, pc;
   logic [31:0] im_data, ir;
   logic [3:0] stat = 4'h0;
   logic [1:0] alu_op;
   logic [31:0] mem [65536];
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   assign im_ack  = auto_ack ? im_req : man_ack;
   assign im_data = mem[im_addr];
   instr_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
      .im_data(im_data), .stat(stat), .ir(ir), .pc(pc), .rf_we(rf_we), .stat_en(stat_en),
      .alu_op(alu_op), .wb_sel(wb_sel), .rd_sel(rd_sel), .halted(halted), .illegal(illegal)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic test_reset;
      man_ack = 1'b0;
      tick();
      tick();
      vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0000", pc); end
      vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL reset_ir got %h want 0", ir); end
      vectors++; if ({im_req, rf_we, stat_en, alu_op, wb_sel, rd_sel, halted, illegal} !== 9'b0)
         begin miscompares++; $display("FAIL reset_ctrl got %b want 0", {im_req, rf_we, stat_en, alu_op, wb_sel, rd_sel, halted, illegal}); end
      rst = 1'b0;
      tick();
      vectors++; if (im_req !== 1'b1 || im_addr !== 16'h0) begin miscompares++; $display("FAIL first_fetch got req=%b addr=%h want 1/0000", im_req, im_addr); end
   endtask
   task automatic test_alu;
      auto_ack = 1'b1;
      tick();
      vectors++; if (ir !== 32'h1012_3000 || pc !== 16'h1) begin miscompares++; $display("FAIL alu_decode got ir=%h pc=%h want 10123000/0001", ir, pc); end
      vectors++; if (stat_en !== 1'b0 || illegal !== 1'b0) begin miscompares++; $display("FAIL alu_decode_strobes got stat_en=%b ill=%b want 0/0", stat_en, illegal); end
      tick();
      vectors++; if (stat_en !== 1'b1 || alu_op !== 2'b01 || rf_we !== 1'b0) begin miscompares++; $display("FAIL alu_exec got stat_en=%b op=%b we=%b want 1/01/0", stat_en, alu_op, rf_we); end
      tick();
      vectors++; if ({rf_we, rd_sel, wb_sel, stat_en, alu_op} !== 6'b111001) begin miscompares++; $display("FAIL alu_wb got %b want 111001", {rf_we, rd_sel, wb_sel, stat_en, alu_op}); end
      tick();
      vectors++; if (im_req !== 1'b1 || im_addr !== 16'h1 || rf_we !== 1'b0) begin miscompares++; $display("FAIL alu_next got req=%b addr=%h we=%b want 1/0001/0", im_req, im_addr, rf_we); end
      tick();
      tick();
      vectors++; if (alu_op !== 2'b10 || stat_en !== 1'b1) begin miscompares++; $display("FAIL imm_exec got op=%b stat_en=%b want 10/1", alu_op, stat_en); end
      tick();
      vectors++; if ({rf_we, rd_sel, wb_sel, alu_op} !== 5'b10110) begin miscompares++; $display("FAIL imm_wb got %b want 10110", {rf_we, rd_sel, wb_sel, alu_op}); end
      tick();
      vectors++; if (im_addr !== 16'h2) begin miscompares++; $display("FAIL imm_next got %h want 0002", im_addr); end
   endtask
   task automatic test_branch;
      logic [3:0]  st [4] = '{4'h4, 4'h0, 4'h4, 4'h0};
      logic [15:0] nx [4] = '{16'h0040, 16'h0041, 16'h0042, 16'h0090};
      for (int i = 0; i < 4; i++) begin
         stat = st[i];
         tick();
         tick();
         vectors++; if (stat_en !== 1'b0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL br_exec_%0d got stat_en=%b we=%b want 0/0", i, stat_en, rf_we); end
         tick();
         vectors++; if (im_addr !== nx[i] || im_req !== 1'b1) begin miscompares++; $display("FAIL br_target_%0d got %h want %h", i, im_addr, nx[i]); end
      end
   endtask
   task automatic test_wrap;
      stat = 4'h4;
      repeat (3) tick();
      vectors++; if (im_addr !== 16'hFFF0) begin miscompares++; $display("FAIL bra_far got %h want fff0", im_addr); end
      stat = 4'h1;
      repeat (3) tick();
      vectors++; if (im_addr !== 16'h0011) begin miscompares++; $display("FAIL brr_wrap got %h want 0011", im_addr); end
      repeat (3) tick();
      vectors++; if (im_addr !== 16'hFFFF) begin miscompares++; $display("FAIL bra_max got %h want ffff", im_addr); end
      tick();
      vectors++; if (pc !== 16'h0 || ir !== 32'h0000_0ABC) begin miscompares++; $display("FAIL pc_wrap got pc=%h ir=%h want 0000/00000abc", pc, ir); end
      tick();
      vectors++; if (im_addr !== 16'h0 || im_req !== 1'b1) begin miscompares++; $display("FAIL nop_latency got req=%b addr=%h want 1/0000", im_req, im_addr); end
   endtask
   task automatic test_ack_delay;
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (im_req !== 1'b1 || im_addr !== 16'h0 || pc !== 16'h0 || ir !== 32'h0000_0ABC)
            begin miscompares++; $display("FAIL wait_%0d got req=%b addr=%h pc=%h ir=%h want 1/0000/0000/00000abc", i, im_req, im_addr, pc, ir); end
      end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      vectors++; if (ir !== 32'h1012_3000 || pc !== 16'h1 || im_req !== 1'b0) begin miscompares++; $display("FAIL late_ack got ir=%h pc=%h req=%b want 10123000/0001/0", ir, pc, im_req); end
      man_ack = 1'b1;
      tick();
      vectors++; if (stat_en !== 1'b1 || ir !== 32'h1012_3000) begin miscompares++; $display("FAIL ack_ignored got stat_en=%b ir=%h want 1/10123000", stat_en, ir); end
      man_ack = 1'b0;
   endtask
   task automatic test_illegal_halt;
      mem[0] = 32'h3000_0000;
      mem[1] = 32'hF000_0000;
      do_reset();
      tick();
      auto_ack = 1'b1;
      tick();
      vectors++; if (illegal !== 1'b1 || rf_we !== 1'b0 || stat_en !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse got ill=%b we=%b se=%b want 1/0/0", illegal, rf_we, stat_en); end
      tick();
      vectors++; if (illegal !== 1'b0 || im_addr !== 16'h1 || im_req !== 1'b1) begin miscompares++; $display("FAIL illegal_resume got ill=%b addr=%h req=%b want 0/0001/1", illegal, im_addr, im_req); end
      tick();
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_decode got %b want 0", halted); end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++; if (halted !== 1'b1 || im_req !== 1'b0 || pc !== 16'h2 || rf_we !== 1'b0)
            begin miscompares++; $display("FAIL halt_%0d got halted=%b req=%b pc=%h we=%b want 1/0/0002/0", i, halted, im_req, pc, rf_we); end
      end
   endtask
   task automatic test_reset_mid;
      mem[0] = 32'h1012_3000;
      do_reset();
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL unhalt got %b want 0", halted); end
      tick();
      auto_ack = 1'b1;
      repeat (3) tick();
      vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL pre_wb got %b want 1", rf_we); end
      auto_ack = 1'b0;
      rst = 1'b1;
      tick();
      vectors++; if (rf_we !== 1'b0 || pc !== 16'h0 || ir !== 32'h0 || im_req !== 1'b0) begin miscompares++; $display("FAIL rst_wb got we=%b pc=%h ir=%h req=%b want 0/0000/0/0", rf_we, pc, ir, im_req); end
      rst = 1'b0;
      tick();
      man_ack = 1'b1;
      rst     = 1'b1;
      tick();
      vectors++; if (ir !== 32'h0 || pc !== 16'h0 || im_req !== 1'b0) begin miscompares++; $display("FAIL rst_ack got ir=%h pc=%h req=%b want 0/0000/0", ir, pc, im_req); end
      man_ack = 1'b0;
      rst     = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      mem[16'h0000] = 32'h1012_3000;
      mem[16'h0001] = 32'h2000_0005;
      mem[16'h0002] = 32'h4400_0040;
      mem[16'h0040] = 32'h4400_0050;
      mem[16'h0041] = 32'h6400_0080;
      mem[16'h0042] = 32'h6400_0090;
      mem[16'h0090] = 32'h4F00_FFF0;
      mem[16'hFFF0] = 32'h5F00_0020;
      mem[16'h0011] = 32'h4F00_FFFF;
      mem[16'hFFFF] = 32'h0000_0ABC;
      test_reset();
      test_alu();
      test_branch();
      test_wrap();
      test_ack_delay();
      test_illegal_halt();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
